mcs_sync_gen: RTL and testbench

Generates the AD9361 multi-chip-sync (MCS) pulse train on the shared mcs_sync pin for both transceivers. Software requests a sequence by toggling an EMIO GPIO bit. The block synchronises that request into the fabric clock and emits a programmable number of fixed-width pulses. It sits between the PS GPIO bank (gpio_o[51]) and the mcs_sync board output, and reports busy/done/overrun status back on spare gpio_i bits.

---
 rtl/mcs_sync_gen.sv | 188 ++++++++++++++++++
 tb/tb_mcs_sync_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs_sync_gen.sv
// rtl/mcs_sync_gen.sv - AD9361 multi-chip-sync pulse train generator
//
// Synchronises a GPIO request level into the clk domain and, on each accepted
// rising edge, emits num_pulses pulses of pulse_len high / gap_len low cycles
// on mcs_sync, followed by a one-cycle done strobe.
//
// Optional feature macro: MCS_SYNC_ALIGN_EN (pulses start on the cycle after ref_tick).
//
// Ports:
//   clk, rstn    fabric clock, asynchronous active-low reset
//   sync_req     asynchronous request level, rising edge starts a sequence
//   ref_tick     alignment strobe (used only with MCS_SYNC_ALIGN_EN)
//   pulse_len    high cycles per pulse (0 treated as 1)
//   gap_len      low cycles between pulses (0 treated as 1)
//   num_pulses   pulses per sequence
//   clr_status   clears overrun
//   mcs_sync     registered pulse output
//   busy         sequence in progress
//   done         one-cycle end-of-sequence strobe
//   overrun      sticky: request edge seen while busy
//   pulse_cnt    pulses emitted in the current or last sequence

module mcs_sync_gen #(
  parameter int CNT_W       = 16,
  parameter int NPULSE_W    = 4,
  parameter int SYNC_STAGES = 3   // must be at least 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sync_req,
  input  logic                ref_tick,
  input  logic [CNT_W-1:0]    pulse_len,
  input  logic [CNT_W-1:0]    gap_len,
  input  logic [NPULSE_W-1:0] num_pulses,
  input  logic                clr_status,
  output logic                mcs_sync,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [NPULSE_W-1:0] pulse_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_HIGH, S_LOW, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      plen_q, plen_d;
  logic [CNT_W-1:0]      glen_q, glen_d;
  logic [NPULSE_W-1:0]   npulse_q, npulse_d;
  logic [NPULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic                  mcs_sync_q, mcs_sync_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;

  logic                  edge_det;
  logic [CNT_W-1:0]      plen_in, glen_in;
  logic [NPULSE_W-1:0]   pulse_cnt_inc;

  // vld_q marks which synchroniser stages hold real post-reset samples, so a
  // request already high at reset release never looks like a 0->1 edge.
  assign edge_det      = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1] & vld_q[SYNC_STAGES-1];
  assign plen_in       = (pulse_len == '0) ? CNT_W'(1) : pulse_len;
  assign glen_in       = (gap_len == '0) ? CNT_W'(1) : gap_len;
  assign pulse_cnt_inc = pulse_cnt_q + 1'b1;

`ifdef MCS_SYNC_ALIGN_EN
`else
  logic unused_ref_tick;
  assign unused_ref_tick = ref_tick;
`endif

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], sync_req};
    vld_d       = {vld_q[SYNC_STAGES-2:0], 1'b1};
    state_d     = state_q;
    cnt_d       = cnt_q;
    plen_d      = plen_q;
    glen_d      = glen_q;
    npulse_d    = npulse_q;
    pulse_cnt_d = pulse_cnt_q;

    // A new overrun edge beats a simultaneous clear.
    overrun_d = overrun_q;
    if (edge_det && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_status) begin
      overrun_d = 1'b0;
    end

    // cnt_q holds remaining cycles minus one in the current HIGH/LOW phase.
    case (state_q)
      S_IDLE: begin
        if (edge_det) begin
          plen_d      = plen_in;
          glen_d      = glen_in;
          npulse_d    = num_pulses;
          pulse_cnt_d = '0;
          cnt_d       = plen_in - 1'b1;
          if (num_pulses == '0) begin
            state_d = S_DONE;
          end else begin
`ifdef MCS_SYNC_ALIGN_EN
            state_d = S_ARM;
`else
            state_d = S_HIGH;
`endif
          end
        end
      end
`ifdef MCS_SYNC_ALIGN_EN
      S_ARM: begin
        if (ref_tick) begin
          state_d = S_HIGH;
          cnt_d   = plen_q - 1'b1;
        end
      end
`endif
      S_HIGH: begin
        if (cnt_q == '0) begin
          pulse_cnt_d = pulse_cnt_inc;
          cnt_d       = glen_q - 1'b1;
          state_d     = (pulse_cnt_inc == npulse_q) ? S_DONE : S_LOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q == '0) begin
`ifdef MCS_SYNC_ALIGN_EN
          state_d = S_ARM;
`else
          state_d = S_HIGH;
          cnt_d   = plen_q - 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered alongside the state so they align with it.
    mcs_sync_d = (state_d == S_HIGH);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      sync_q      <= '0;
      vld_q       <= '0;
      cnt_q       <= '0;
      plen_q      <= '0;
      glen_q      <= '0;
      npulse_q    <= '0;
      pulse_cnt_q <= '0;
      mcs_sync_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      vld_q       <= vld_d;
      cnt_q       <= cnt_d;
      plen_q      <= plen_d;
      glen_q      <= glen_d;
      npulse_q    <= npulse_d;
      pulse_cnt_q <= pulse_cnt_d;
      mcs_sync_q  <= mcs_sync_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign mcs_sync  = mcs_sync_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_mcs_sync_gen.sv
// tb/tb_mcs_sync_gen.sv - self-checking bench for mcs_sync_gen (default build)

module tb_mcs_sync_gen;

  localparam int CNT_W    = 16;
  localparam int NPULSE_W = 4;
  localparam int MAXC     = 4096;

  logic                clk        = 1'b0;
  logic                rstn       = 1'b0;
  logic                sync_req   = 1'b0;
  logic                ref_tick   = 1'b0;
  logic                clr_status = 1'b0;
  logic [CNT_W-1:0]    pulse_len  = '0;
  logic [CNT_W-1:0]    gap_len    = '0;
  logic [NPULSE_W-1:0] num_pulses = '0;
  logic                mcs_sync, busy, done, overrun;
  logic [NPULSE_W-1:0] pulse_cnt;

  mcs_sync_gen #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W), .SYNC_STAGES(3)) dut (
    .clk(clk), .rstn(rstn), .sync_req(sync_req), .ref_tick(ref_tick),
    .pulse_len(pulse_len), .gap_len(gap_len), .num_pulses(num_pulses),
    .clr_status(clr_status), .mcs_sync(mcs_sync), .busy(busy), .done(done),
    .overrun(overrun), .pulse_cnt(pulse_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model. Cycle t means "the value right after posedge t". samp[t] is sync_req
  // as sampled at posedge t. A sequence accepted at posedge s_t is described by
  // its latched parameters and evaluated by arithmetic on t - s_t.
  int cyc        = 0;
  int first_real = 1;
  bit samp [MAXC];
  bit have_seq   = 1'b0;
  int s_t, s_p, s_g, s_n;
  bit m_ovr      = 1'b0;

  bit obs_ms [MAXC];
  bit obs_bz [MAXC];
  bit obs_dn [MAXC];
  bit obs_ov [MAXC];
  int obs_pc [MAXC];

  function automatic void model_at(input int t, output bit ms, output bit bz,
                                   output bit dn, output int pc);
    int d, per, len;
    ms = 1'b0; bz = 1'b0; dn = 1'b0; pc = 0;
    if (!have_seq) return;
    d = t - s_t;
    if (s_n == 0) begin
      bz = (d == 0);
      dn = (d == 0);
    end else begin
      per = s_p + s_g;
      len = s_n * s_p + (s_n - 1) * s_g;
      if (d < len) begin
        bz = 1'b1;
        ms = ((d % per) < s_p);
        pc = d / per + (((d % per) >= s_p) ? 1 : 0);
      end else begin
        pc = s_n;
        if (d == len) begin
          bz = 1'b1;
          dn = 1'b1;
        end
      end
    end
  endfunction

  always @(posedge clk) begin : model_p
    bit ms, bz, dn, setov;
    int pc;
    cyc = cyc + 1;
    if (!rstn) begin
      first_real = cyc + 1;
      have_seq   = 1'b0;
      m_ovr      = 1'b0;
    end else if (cyc < MAXC) begin
      samp[cyc] = sync_req;
      setov = 1'b0;
      // Three stages: a 0->1 at samples (t-3, t-2) reaches the state machine at posedge t.
      if ((cyc - 3 >= first_real) && samp[cyc-2] && !samp[cyc-3]) begin
        model_at(cyc - 1, ms, bz, dn, pc);
        if (bz) begin
          setov = 1'b1;
        end else begin
          have_seq = 1'b1;
          s_t = cyc;
          s_p = (pulse_len == 0) ? 1 : int'(pulse_len);
          s_g = (gap_len == 0) ? 1 : int'(gap_len);
          s_n = int'(num_pulses);
        end
      end
      if (setov) m_ovr = 1'b1;
      else if (clr_status) m_ovr = 1'b0;
    end
  end

  always @(negedge clk) begin : compare_p
    bit ms, bz, dn;
    int pc;
    if (!rstn) begin
      ms = 1'b0; bz = 1'b0; dn = 1'b0; pc = 0;
      check("rst_overrun", overrun, 0);
    end else begin
      model_at(cyc, ms, bz, dn, pc);
      check("overrun", overrun, m_ovr);
    end
    check("mcs_sync", mcs_sync, ms);
    check("busy", busy, bz);
    check("done", done, dn);
    check("pulse_cnt", pulse_cnt, pc);
    if (cyc < MAXC) begin
      obs_ms[cyc] = mcs_sync;
      obs_bz[cyc] = busy;
      obs_dn[cyc] = done;
      obs_ov[cyc] = overrun;
      obs_pc[cyc] = int'(pulse_cnt);
    end
  end

  int k, r0, acc;

  initial begin
    // Test 1: reset with request already high; no sequence may start.
    sync_req = 1'b1;
    repeat (3) @(negedge clk);
    check("t1_rst_mcs", mcs_sync, 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_done", done, 0);
    check("t1_rst_pcnt", pulse_cnt, 0);
    rstn = 1'b1;
    r0 = cyc + 1;
    repeat (100) @(negedge clk);
    acc = 0;
    for (int i = r0; i < cyc; i++) begin
      acc += obs_ms[i];
      acc += obs_bz[i];
      acc += obs_dn[i];
    end
    check("t1_quiet", acc, 0);
    sync_req = 1'b0;
    repeat (5) @(negedge clk);

    // Test 2 + 5: 3 pulses of 4 high / 2 low; config changed and a second
    // request edge arrive mid-sequence.
    pulse_len = 16'd4; gap_len = 16'd2; num_pulses = 4'd3;
    sync_req = 1'b1; k = cyc + 1;
    repeat (3) @(negedge clk);
    pulse_len = 16'd9; gap_len = 16'd7; num_pulses = 4'd5;
    repeat (5) @(negedge clk);
    sync_req = 1'b0;
    repeat (2) @(negedge clk);
    sync_req = 1'b1;
    repeat (15) @(negedge clk);
    check("t2_ms_k1", obs_ms[k+1], 0);
    check("t2_ms_k2", obs_ms[k+2], 1);
    check("t2_ms_k5", obs_ms[k+5], 1);
    check("t2_ms_k6", obs_ms[k+6], 0);
    check("t2_ms_k7", obs_ms[k+7], 0);
    check("t2_ms_k8", obs_ms[k+8], 1);
    check("t2_ms_k17", obs_ms[k+17], 1);
    check("t2_ms_k18", obs_ms[k+18], 0);
    check("t2_done_k17", obs_dn[k+17], 0);
    check("t2_done_k18", obs_dn[k+18], 1);
    check("t2_busy_k18", obs_bz[k+18], 1);
    check("t2_busy_k19", obs_bz[k+19], 0);
    check("t2_pcnt_k19", obs_pc[k+19], 3);
    acc = 0;
    for (int i = k; i < k + 24; i++) acc += obs_ms[i];
    check("t2_high_cycles", acc, 12);
    check("t5_ovr_k11", obs_ov[k+11], 0);
    check("t5_ovr_k12", obs_ov[k+12], 1);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    check("t5_ovr_clr", obs_ov[cyc-1], 0);

    // Test 3: num_pulses = 0 gives only a done strobe.
    sync_req = 1'b0;
    repeat (4) @(negedge clk);
    pulse_len = 16'd4; gap_len = 16'd2; num_pulses = 4'd0;
    sync_req = 1'b1; k = cyc + 1;
    repeat (6) @(negedge clk);
    acc = 0;
    for (int i = k; i < k + 5; i++) acc += obs_ms[i];
    check("t3_no_high", acc, 0);
    check("t3_done_k2", obs_dn[k+2], 1);
    check("t3_done_k3", obs_dn[k+3], 0);
    check("t3_busy_k3", obs_bz[k+3], 0);
    check("t3_pcnt", obs_pc[k+3], 0);

    // Test 4: zero lengths behave as one cycle.
    sync_req = 1'b0;
    repeat (4) @(negedge clk);
    pulse_len = 16'd0; gap_len = 16'd0; num_pulses = 4'd2;
    sync_req = 1'b1; k = cyc + 1;
    repeat (8) @(negedge clk);
    check("t4_ms_k2", obs_ms[k+2], 1);
    check("t4_ms_k3", obs_ms[k+3], 0);
    check("t4_ms_k4", obs_ms[k+4], 1);
    check("t4_done_k5", obs_dn[k+5], 1);
    check("t4_pcnt", obs_pc[k+6], 2);

    // Overrun edge coinciding with clr_status: set wins.
    sync_req = 1'b0;
    repeat (4) @(negedge clk);
    pulse_len = 16'd6; gap_len = 16'd1; num_pulses = 4'd2;
    sync_req = 1'b1; k = cyc + 1;
    repeat (4) @(negedge clk);
    sync_req = 1'b0;
    repeat (2) @(negedge clk);
    sync_req = 1'b1;
    repeat (2) @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    check("setwin_ovr_k7", obs_ov[k+7], 0);
    check("setwin_ovr_k8", obs_ov[k+8], 1);
    repeat (10) @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    @(negedge clk);
    check("setwin_ovr_clr", overrun, 0);

    // Asynchronous reset mid-pulse drops outputs immediately; request held high
    // across release must not restart.
    sync_req = 1'b0;
    repeat (4) @(negedge clk);
    pulse_len = 16'd20; gap_len = 16'd1; num_pulses = 4'd1;
    sync_req = 1'b1; k = cyc + 1;
    repeat (6) @(negedge clk);
    check("arst_pre_ms", mcs_sync, 1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_ms", mcs_sync, 0);
    check("arst_busy", busy, 0);
    check("arst_pcnt", pulse_cnt, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_no_restart", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
